// File: rtl/mccoy_instr_sequencer_if.sv
// Program-load, control and core-facing signals of the McCoy instruction sequencer.
// master = controller/bench side, slave = sequencer side.
interface mccoy_instr_sequencer_if #(
  parameter int IW = 6,
  parameter int AW = 4
);
  logic          clr;
  logic          wr_en;
  logic [IW-1:0] wr_data;
  logic          wr_ready;
  logic          start;
  logic          loop_en;
  logic          core_reset;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic [AW:0]   len;

  modport master (
    output clr, wr_en, wr_data, start, loop_en,
    input  wr_ready, core_reset, instr_out, instr_valid, busy, done, len
  );

  modport slave (
    input  clr, wr_en, wr_data, start, loop_en,
    output wr_ready, core_reset, instr_out, instr_valid, busy, done, len
  );
endinterface

// File: rtl/mccoy_instr_sequencer.sv
// Buffers a short program, pulses core reset for RST_CYCLES, then plays one entry per clock (first entry RST_CYCLES+1 edges after start).
// Writes are accepted only in IDLE with free space (wr_ready); other writes are dropped, never stalled.
module mccoy_instr_sequencer #(
  parameter int IW         = 6,
  parameter int DEPTH      = 16,
  parameter int AW         = 4,
  parameter int RST_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mccoy_instr_sequencer_if.slave  bus
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CORE_RST, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          core_reset_q, core_reset_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [IW-1:0] mem_q [DEPTH];

  logic          wr_ready;
  logic          wr_fire;
  logic          last_entry;
  logic [AW-1:0] pc_next;

  assign wr_ready   = (state_q == IDLE) && (len_q < (AW+1)'(DEPTH));
  assign last_entry = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));
  assign pc_next    = pc_q + AW'(1);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    pc_d          = pc_q;
    rcnt_d        = rcnt_q;
    core_reset_d  = core_reset_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    done_d        = done_q;
    wr_fire       = 1'b0;

    if (bus.clr) begin
      state_d       = IDLE;
      len_d         = '0;
      pc_d          = '0;
      rcnt_d        = '0;
      core_reset_d  = 1'b0;
      instr_d       = '0;
      instr_valid_d = 1'b0;
      done_d        = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // start outranks a same-cycle write, which is then lost
          if (bus.start && (len_q != '0)) begin
            state_d      = CORE_RST;
            rcnt_d       = '0;
            core_reset_d = 1'b1;
          end else if (bus.wr_en && wr_ready) begin
            wr_fire = 1'b1;
            len_d   = len_q + (AW+1)'(1);
          end
        end
        CORE_RST: begin
          if (rcnt_q == RW'(RST_CYCLES - 1)) begin
            state_d       = RUN;
            pc_d          = '0;
            core_reset_d  = 1'b0;
            instr_d       = mem_q[0];
            instr_valid_d = 1'b1;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        RUN: begin
          if (last_entry) begin
            if (bus.loop_en) begin
              pc_d    = '0;
              instr_d = mem_q[0];
            end else begin
              state_d       = DONE;
              instr_d       = '0;
              instr_valid_d = 1'b0;
              done_d        = 1'b1;
            end
          end else begin
            pc_d    = pc_next;
            instr_d = mem_q[pc_next];
          end
        end
        DONE: begin
          if (bus.start) begin
            state_d      = CORE_RST;
            rcnt_d       = '0;
            core_reset_d = 1'b1;
            done_d       = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == CORE_RST) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      pc_q          <= '0;
      rcnt_q        <= '0;
      core_reset_q  <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      pc_q          <= pc_d;
      rcnt_q        <= rcnt_d;
      core_reset_q  <= core_reset_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Program storage is not reset; len_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[len_q[AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.core_reset  = core_reset_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.len         = len_q;

endmodule

// File: tb/tb_mccoy_instr_sequencer.sv
// Directed bench for mccoy_instr_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_mccoy_instr_sequencer;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  mccoy_instr_sequencer_if #(.IW(6), .AW(4)) bus ();

  mccoy_instr_sequencer #(.IW(6), .DEPTH(16), .AW(4), .RST_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr, wr, st, lp;
    logic [5:0] wd;
    logic       cr;
    logic [5:0] ins;
    logic       v, bsy, dn;
    logic [4:0] ln;
    logic       rdy;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic c, logic w, logic s, logic l, logic [5:0] d,
                              logic cr, logic [5:0] i, logic v, logic b, logic dn,
                              logic [4:0] ln, logic r);
    vec_t t;
    t.clr = c; t.wr = w; t.st = s; t.lp = l; t.wd = d;
    t.cr = cr; t.ins = i; t.v = v; t.bsy = b; t.dn = dn; t.ln = ln; t.rdy = r;
    return t;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic c, logic w, logic s, logic l, logic [5:0] d);
    bus.clr = c; bus.wr_en = w; bus.start = s; bus.loop_en = l; bus.wr_data = d;
  endtask

  task automatic chk_all(string tag, logic cr, logic [5:0] ins, logic v, logic b,
                         logic dn, logic [4:0] ln, logic r);
    chk({tag, ".core_reset"},  int'(bus.core_reset),  int'(cr));
    chk({tag, ".instr_out"},   int'(bus.instr_out),   int'(ins));
    chk({tag, ".instr_valid"}, int'(bus.instr_valid), int'(v));
    chk({tag, ".busy"},        int'(bus.busy),        int'(b));
    chk({tag, ".done"},        int'(bus.done),        int'(dn));
    chk({tag, ".len"},         int'(bus.len),         int'(ln));
    chk({tag, ".wr_ready"},    int'(bus.wr_ready),    int'(r));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    //                clr wr st lp data        cr ins        v  b  dn len r
    tbl[0]  = mk(0, 1, 0, 0, 6'b011001, 0, 6'b000000, 0, 0, 0, 5'd1, 1);
    tbl[1]  = mk(0, 1, 0, 0, 6'b000011, 0, 6'b000000, 0, 0, 0, 5'd2, 1);
    tbl[2]  = mk(0, 1, 0, 0, 6'b100000, 0, 6'b000000, 0, 0, 0, 5'd3, 1);
    tbl[3]  = mk(0, 0, 1, 0, 6'b000000, 1, 6'b000000, 0, 1, 0, 5'd3, 0);
    tbl[4]  = mk(0, 0, 0, 0, 6'b000000, 1, 6'b000000, 0, 1, 0, 5'd3, 0);
    tbl[5]  = mk(0, 0, 0, 0, 6'b000000, 0, 6'b011001, 1, 1, 0, 5'd3, 0);
    tbl[6]  = mk(0, 0, 0, 0, 6'b000000, 0, 6'b000011, 1, 1, 0, 5'd3, 0);
    tbl[7]  = mk(0, 0, 0, 0, 6'b000000, 0, 6'b100000, 1, 1, 0, 5'd3, 0);
    tbl[8]  = mk(0, 0, 0, 0, 6'b000000, 0, 6'b000000, 0, 0, 1, 5'd3, 0);
    tbl[9]  = mk(0, 1, 0, 0, 6'b111111, 0, 6'b000000, 0, 0, 1, 5'd3, 0);
    tbl[10] = mk(0, 1, 1, 0, 6'b111111, 1, 6'b000000, 0, 1, 0, 5'd3, 0);
    tbl[11] = mk(0, 0, 0, 0, 6'b000000, 1, 6'b000000, 0, 1, 0, 5'd3, 0);
    tbl[12] = mk(0, 0, 0, 0, 6'b000000, 0, 6'b011001, 1, 1, 0, 5'd3, 0);
    tbl[13] = mk(0, 0, 0, 0, 6'b000000, 0, 6'b000011, 1, 1, 0, 5'd3, 0);
    tbl[14] = mk(0, 0, 0, 0, 6'b000000, 0, 6'b100000, 1, 1, 0, 5'd3, 0);
    tbl[15] = mk(0, 0, 0, 0, 6'b000000, 0, 6'b000000, 0, 0, 1, 5'd3, 0);
    tbl[16] = mk(1, 0, 1, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 5'd0, 1);
    tbl[17] = mk(0, 0, 1, 0, 6'b000000, 0, 6'b000000, 0, 0, 0, 5'd0, 1);
    tbl[18] = mk(0, 1, 0, 0, 6'b000111, 0, 6'b000000, 0, 0, 0, 5'd1, 1);
    tbl[19] = mk(0, 1, 1, 0, 6'b001000, 1, 6'b000000, 0, 1, 0, 5'd1, 0);
    tbl[20] = mk(0, 0, 0, 0, 6'b000000, 1, 6'b000000, 0, 1, 0, 5'd1, 0);
    tbl[21] = mk(0, 0, 0, 0, 6'b000000, 0, 6'b000111, 1, 1, 0, 5'd1, 0);
    tbl[22] = mk(0, 0, 0, 0, 6'b000000, 0, 6'b000000, 0, 0, 1, 5'd1, 0);

    drive(0, 0, 0, 0, 6'd0);
    reset_n = 1'b0;
    #12;
    chk_all("reset", 0, 6'd0, 0, 0, 0, 5'd0, 1);
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].clr, tbl[i].wr, tbl[i].st, tbl[i].lp, tbl[i].wd);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].cr, tbl[i].ins, tbl[i].v,
              tbl[i].bsy, tbl[i].dn, tbl[i].ln, tbl[i].rdy);
    end

    // Fill to capacity, attempt an overflow write, then play back every entry.
    drive(1, 0, 0, 0, 6'd0); step();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, 0, 6'(i)); step();
    end
    chk("full.len", int'(bus.len), 16);
    chk("full.wr_ready", int'(bus.wr_ready), 0);
    drive(0, 1, 0, 0, 6'd63); step();
    chk("overflow.len", int'(bus.len), 16);
    drive(0, 0, 1, 0, 6'd0); step();
    chk("full.core_reset", int'(bus.core_reset), 1);
    drive(0, 0, 0, 0, 6'd0); step();
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("full.instr%0d", i), int'(bus.instr_out), i);
    end
    step();
    chk("full.done", int'(bus.done), 1);

    // Looping two-entry program, then loop_en dropped while A is shown.
    drive(1, 0, 0, 0, 6'd0); step();
    drive(0, 1, 0, 0, 6'h2A); step();
    drive(0, 1, 0, 0, 6'h15); step();
    drive(0, 0, 1, 1, 6'd0); step();
    drive(0, 0, 0, 1, 6'd0); step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("loop.instr%0d", i), int'(bus.instr_out), (i % 2 == 0) ? 'h2A : 'h15);
      chk($sformatf("loop.valid%0d", i), int'(bus.instr_valid), 1);
    end
    step();
    chk("loop.wrapA", int'(bus.instr_out), 'h2A);
    bus.loop_en = 1'b0;
    step();
    chk("loop.lastB", int'(bus.instr_out), 'h15);
    step();
    chk("loop.done", int'(bus.done), 1);
    chk("loop.valid_off", int'(bus.instr_valid), 0);

    // clr while the second instruction is on the bus.
    drive(0, 0, 1, 0, 6'd0); step();
    drive(0, 0, 0, 0, 6'd0); step();
    step();
    chk("clrrun.first", int'(bus.instr_out), 'h2A);
    step();
    chk("clrrun.second", int'(bus.instr_out), 'h15);
    drive(1, 0, 0, 0, 6'd0); step();
    drive(0, 0, 0, 0, 6'd0);
    chk_all("clrrun", 0, 6'd0, 0, 0, 0, 5'd0, 1);

    // Asynchronous reset in the middle of the core reset pulse.
    drive(0, 1, 0, 0, 6'd1); step();
    drive(0, 1, 0, 0, 6'd2); step();
    drive(0, 0, 1, 0, 6'd0); step();
    drive(0, 0, 0, 0, 6'd0);
    chk("arst.pre_core_reset", int'(bus.core_reset), 1);
    #3 reset_n = 1'b0;
    #1;
    chk_all("arst", 0, 6'd0, 0, 0, 0, 5'd0, 1);
    #2 reset_n = 1'b1;
    step();
    chk_all("arst.after", 0, 6'd0, 0, 0, 0, 5'd0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mccoy_instr_sequencer.md
Name: mccoy_instr_sequencer

Overview:
Upstream program feeder for the McCoy core. It buffers a short program of 6-bit instructions written over a valid/ready port. On command it pulses the core's active-high reset, then drives one instruction per clock onto the core's instr[5:0] input. Playback runs once or loops. All outputs are registered so they map directly onto io_in[6:0] of the core.

Parameters:
IW, 6, instruction width (matches core instr field)
DEPTH, 16, program buffer entries (power of two)
AW, 4, log2(DEPTH)
RST_CYCLES, 2, cycles core_reset is held high before playback (>=1)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear: empty buffer, return to IDLE
wr_en  in  1  write strobe for program load
wr_data  in  IW  instruction to append
wr_ready  out  1  buffer accepts a write this cycle
start  in  1  begin core reset plus playback
loop_en  in  1  1 = wrap to entry 0 after last entry
core_reset  out  1  active-high reset to core
instr_out  out  IW  instruction to core
instr_valid  out  1  instr_out carries a program entry
busy  out  1  state is CORE_RST or RUN
done  out  1  single pass finished
len  out  AW+1  number of stored entries

Behaviour:
- Clock and reset: single clock, clk. reset_n is asynchronous and active-low.
- Reset (reset_n=0, async): state=IDLE, len=0, pc=0, rcnt=0. core_reset=0, instr_out=0, instr_valid=0, busy=0, done=0. wr_ready=1 (combinational, see below).
- States: IDLE, CORE_RST, RUN, DONE. Priority each edge: clr > start > wr_en.
- wr_ready = (state==IDLE) && (len<DEPTH). It is combinational from registered state.
- IDLE:
  - wr_en && wr_ready: mem[len]<=wr_data, len<=len+1.
  - wr_en when wr_ready=0 is ignored; nothing is overwritten.
  - start && len>0 -> CORE_RST, rcnt<=0. start with len==0 is ignored.
  - start with wr_en in the same cycle: start wins and the write is dropped.
- CORE_RST:
  - core_reset=1 for exactly RST_CYCLES cycles, counted by rcnt.
  - Then -> RUN with pc=0. instr_out and instr_valid stay 0.
- RUN:
  - instr_out=mem[pc], instr_valid=1. pc advances by 1 each edge.
  - When pc==len-1 at an edge and loop_en=1 (sampled that edge): pc<=0, stay in RUN.
  - When pc==len-1 and loop_en=0: -> DONE, instr_out<=0, instr_valid<=0.
  - len==1 with loop_en=1 repeats mem[0] every cycle.
- DONE:
  - done=1 and held.
  - start -> CORE_RST and replays the same program. done drops the same edge.
  - Writes are ignored in DONE.
- Timing: start sampled at edge k gives core_reset=1 after edges k .. k+RST_CYCLES-1. mem[0] appears on instr_out after edge k+RST_CYCLES. Entry i appears after edge k+RST_CYCLES+i. First-instruction latency = RST_CYCLES+1 edges from start.
- clr in any state (including mid-RUN or CORE_RST):
  - Next edge: IDLE, len=0, pc=0, core_reset=0, instr_out=0, instr_valid=0, done=0.
  - Buffer contents need not be erased.
- Async reset mid-playback: immediate return to reset values, including core_reset=0. The core itself is re-reset only by the next start.
- busy = (state==CORE_RST)||(state==RUN), registered alongside state.
- pc is AW bits wide. len ranges 0..DEPTH and uses AW+1 bits. No arithmetic wraps beyond these widths.

Test Plan:
- Reset then load 3 entries 6'b011001, 6'b000011, 6'b100000 -> len=3, wr_ready=1. Outputs stay 0.
- start (RST_CYCLES=2, loop_en=0) at edge k -> core_reset=1 after edges k, k+1. instr_out=011001, 000011, 100000 after edges k+2, k+3, k+4. Then DONE, done=1, instr_out=0, instr_valid=0.
- Fill 16 entries then assert one more wr_en -> wr_ready=0 and len stays 16. start with len=0 after clr -> stays IDLE, core_reset never rises.
- loop_en=1 with 2 entries A, B -> instr_out sequence A, B, A, B, A ... for 10 cycles. Dropping loop_en before the B cycle -> DONE after B.
- clr asserted mid-RUN on the 2nd instruction -> next cycle IDLE, len=0, instr_valid=0, wr_ready=1. Simultaneous start+clr -> clr wins.
- reset_n pulsed low mid-CORE_RST, asynchronously between edges -> core_reset drops immediately, all outputs at reset values. start in DONE replays the program identically.
